// File: rtl/mem_bank_b_read_sequencer.sv
// Bank-B read sequencer: issues fixed-length read bursts, n per pass,
// for a number of passes. Each burst waits for downstream room first.
module mem_bank_b_read_sequencer #(
  parameter int ARRAY_WIDTH      = 4,
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] n,
  input  logic [15:0] passes,
  input  logic        ready_i,
  output logic        valid_o,
  output logic        last_o,
  output logic        pass_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic [31:0] beat_count_o
);

  localparam int BURST =
    BUS_WIDTH_BYTES / DATA_WIDTH_BYTES / ARRAY_WIDTH;
  localparam int BW = $clog2(BURST);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_idx;
  logic [15:0]   burst_idx;
  logic [15:0]   pass_idx;
  logic [15:0]   n_q;
  logic [15:0]   passes_q;

  logic [BW-1:0] beat_nxt;
  logic          burst_end;
  logic          final_burst;
  logic          final_pass;
  logic          gap;

  assign beat_nxt    = beat_idx + 1'b1;
  assign burst_end   = (beat_nxt == BEAT_LAST);
  assign final_burst = (burst_idx == n_q - 16'd1);
  assign final_pass  = (pass_idx == passes_q - 16'd1);
  // ready_i is only looked at between bursts
  assign gap         = !valid_o || last_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat_idx     <= '0;
      burst_idx    <= '0;
      pass_idx     <= '0;
      n_q          <= '0;
      passes_q     <= '0;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      pass_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      beat_count_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            n_q          <= n;
            passes_q     <= passes;
            beat_idx     <= '0;
            burst_idx    <= '0;
            pass_idx     <= '0;
            beat_count_o <= '0;
            aborted_o    <= 1'b0;
            busy_o       <= 1'b1;
            if (n == 16'd0 || passes == 16'd0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          beat_count_o <= beat_count_o + 32'(valid_o);
          if (abort_i) begin
            state       <= IDLE;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            pass_last_o <= 1'b0;
            busy_o      <= 1'b0;
            aborted_o   <= 1'b1;
          end else if (!gap) begin
            beat_idx    <= beat_nxt;
            last_o      <= burst_end;
            pass_last_o <= burst_end && final_burst;
          end else begin
            if (last_o) begin
              if (final_burst) begin
                burst_idx <= '0;
                pass_idx  <= pass_idx + 16'd1;
              end else begin
                burst_idx <= burst_idx + 16'd1;
              end
            end
            beat_idx    <= '0;
            last_o      <= 1'b0;
            pass_last_o <= 1'b0;
            if (pass_last_o && final_pass) begin
              state   <= DONE;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              valid_o <= ready_i;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
          if (abort_i) aborted_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_b_read_sequencer.sv
// Directed bench for the bank-B read sequencer: job table plus
// hand-written abort, reset and idle corner cases.
module tb_mem_bank_b_read_sequencer;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic        abort_i;
  logic [15:0] n;
  logic [15:0] passes;
  logic        ready_i;
  logic        valid_o;
  logic        last_o;
  logic        pass_last_o;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [31:0] beat_count_o;

  int tests;
  int failed;

  mem_bank_b_read_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .n            (n),
    .passes       (passes),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .pass_last_o  (pass_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .beat_count_o (beat_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int p;
    int low;
    int hold;
    int e_first;
    int e_last;
    int e_done;
    int e_beats;
    int e_lasts;
    int e_plasts;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle start_i is high; sampling is at negedge.
  task automatic run_job(
    input  int nn, input int pp, input int low,
    input  int hold, input int skip_wait,
    output int first, output int lastc, output int donec,
    output int beats, output int lasts, output int plasts,
    output int bc, output int viol
  );
    first = -1; lastc = -1; donec = -1;
    beats = 0; lasts = 0; plasts = 0; bc = -1; viol = 0;
    if (skip_wait == 0) @(negedge clk);
    n = 16'(nn);
    passes = 16'(pp);
    start_i = 1'b1;
    ready_i = (low != 0);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (valid_o) begin
        beats++;
        if (first < 0) first = c;
      end
      if (last_o) begin
        lasts++;
        if (lastc < 0) lastc = c;
        if (!valid_o) viol++;
      end
      if (pass_last_o) begin
        plasts++;
        if (!last_o) viol++;
      end
      if (done_o) begin
        donec = c;
        bc = int'(beat_count_o);
        break;
      end
      start_i = (hold != 0);
      if (hold != 0 && c == 3) begin
        n = 16'd7;
        passes = 16'd9;
      end
      ready_i = (c != low);
    end
    start_i = 1'b0;
    ready_i = 1'b1;
  endtask

  int first, lastc, donec, beats, lasts, plasts, bc, viol;
  int seen_done;

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    start_i = 1'b1;
    abort_i = 1'b0;
    n = 16'd2;
    passes = 16'd1;
    ready_i = 1'b1;

    tbl[0] = '{2, 1, -1, 0,  2,  9, 18, 16, 2, 1};
    tbl[1] = '{2, 1,  9, 0,  2,  9, 19, 16, 2, 1};
    tbl[2] = '{0, 5, -1, 0, -1, -1,  1,  0, 0, 0};
    tbl[3] = '{3, 2, -1, 0,  2,  9, 50, 48, 6, 2};
    tbl[4] = '{1, 1, -1, 0,  2,  9, 10,  8, 1, 1};
    tbl[5] = '{4, 0, -1, 0, -1, -1,  1,  0, 0, 0};
    tbl[6] = '{1, 3,  9, 0,  2,  9, 27, 24, 3, 3};
    tbl[7] = '{2, 1,  5, 0,  2,  9, 18, 16, 2, 1};
    tbl[8] = '{2, 2, -1, 1,  2,  9, 34, 32, 4, 2};

    repeat (3) @(negedge clk);
    check("rst_valid", int'(valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_count", int'(beat_count_o), 0);
    reset = 1'b0;
    start_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].n, tbl[i].p, tbl[i].low, tbl[i].hold, 0,
              first, lastc, donec, beats, lasts, plasts, bc, viol);
      check($sformatf("v%0d_first", i), first, tbl[i].e_first);
      check($sformatf("v%0d_last", i), lastc, tbl[i].e_last);
      check($sformatf("v%0d_done", i), donec, tbl[i].e_done);
      check($sformatf("v%0d_beats", i), beats, tbl[i].e_beats);
      check($sformatf("v%0d_lasts", i), lasts, tbl[i].e_lasts);
      check($sformatf("v%0d_plasts", i), plasts, tbl[i].e_plasts);
      check($sformatf("v%0d_count", i), bc, tbl[i].e_beats);
      check($sformatf("v%0d_proto", i), viol, 0);
      @(negedge clk);
      check($sformatf("v%0d_idle", i), int'(busy_o), 0);
      check($sformatf("v%0d_abflag", i), int'(aborted_o), 0);
    end

    // abort on the 4th beat of burst 1 (cycle 13)
    @(negedge clk);
    n = 16'd3;
    passes = 16'd2;
    ready_i = 1'b1;
    start_i = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 13) begin
        check("ab_valid_before", int'(valid_o), 1);
        abort_i = 1'b1;
      end
    end
    @(negedge clk);
    abort_i = 1'b0;
    check("ab_valid", int'(valid_o), 0);
    check("ab_last", int'(last_o), 0);
    check("ab_flag", int'(aborted_o), 1);
    check("ab_busy", int'(busy_o), 0);
    check("ab_count", int'(beat_count_o), 12);
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o || valid_o) seen_done++;
    end
    check("ab_quiet", seen_done, 0);
    check("ab_hold_count", int'(beat_count_o), 12);

    // abort in idle with start: abort wins, no effect on flag
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("idle_abort_busy", int'(busy_o), 0);
    check("idle_abort_flag", int'(aborted_o), 1);

    // reset mid-burst, then start in first cycle out of reset
    n = 16'd2;
    passes = 16'd1;
    start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("rb_valid_before", int'(valid_o), 1);
    reset = 1'b1;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort_i = 1'b0;
    check("rb_valid", int'(valid_o), 0);
    check("rb_busy", int'(busy_o), 0);
    check("rb_count", int'(beat_count_o), 0);
    check("rb_flag", int'(aborted_o), 0);
    run_job(1, 1, -1, 0, 1,
            first, lastc, donec, beats, lasts, plasts, bc, viol);
    check("rb_first", first, 2);
    check("rb_done", donec, 10);
    check("rb_beats", beats, 8);
    check("rb_count_done", bc, 8);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_bank_b_read_sequencer.md
MEM_BANK_B_READ_SEQUENCER -- requirements
Module: mem_bank_b_read_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 4, processing-array width in elements.
REQ-002 SHALL have parameter BUS_WIDTH_BYTES, default 32, memory bus width.
REQ-003 SHALL have parameter DATA_WIDTH_BYTES, default 1, element width.
REQ-004 SHALL derive BURST = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES / ARRAY_WIDTH (default 8), a power of two >= 2.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1, single-cycle job start pulse.
REQ-008 SHALL have port abort_i, input, 1, cancels the current job.
REQ-009 SHALL have port n, input, 16, bursts per pass.
REQ-010 SHALL have port passes, input, 16, passes per job.
REQ-011 SHALL have port ready_i, input, 1, downstream has room for one full burst.
REQ-012 SHALL have port valid_o, output, 1, one read beat per high cycle; drives the bank-B address generator valid_i.
REQ-013 SHALL have port last_o, output, 1, marks the final beat of a burst.
REQ-014 SHALL have port pass_last_o, output, 1, marks the final beat of a pass.
REQ-015 SHALL have port busy_o, output, 1, job in progress.
REQ-016 SHALL have port done_o, output, 1, single-cycle job-complete pulse.
REQ-017 SHALL have port aborted_o, output, 1, sticky flag: last job was aborted.
REQ-018 SHALL have port beat_count_o, output, 32, beats issued in the current job.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE; busy_o = (state != IDLE).
REQ-020 SHALL, in IDLE when start_i=1 and abort_i=0, latch n and passes, clear beat_count_o and aborted_o, and move to RUN (or to DONE if n==0 or passes==0).
REQ-021 SHALL ignore start_i while not in IDLE; later changes on n and passes SHALL NOT affect a running job.
REQ-022 SHALL register all outputs; valid_o, last_o and pass_last_o SHALL NOT depend combinationally on any input.
REQ-023 SHALL sample ready_i in RUN only in cycles where valid_o=0 or last_o=1, and only while bursts remain.
REQ-024 SHALL, when sampled ready_i=1, assert valid_o for exactly BURST consecutive cycles starting the next cycle; ready_i is ignored inside a burst.
REQ-025 SHALL keep beat index 0..BURST-1, burst index 0..n-1 and pass index 0..passes-1 counters; bursts are never split.
REQ-026 SHALL assert last_o with beat BURST-1.
REQ-027 SHALL assert pass_last_o with beat BURST-1 of burst n-1.
REQ-028 SHALL run back-to-back bursts with no gap when ready_i=1 at each last_o.
REQ-029 SHALL, after the final beat of the final pass, enter DONE for exactly one cycle with done_o=1, then return to IDLE.
REQ-030 SHALL increment beat_count_o on every valid_o cycle, wrapping modulo 2^32.
REQ-031 SHALL, on abort_i=1 in RUN or DONE, enter IDLE next cycle with valid_o, last_o, pass_last_o and done_o at 0 and aborted_o=1; beat_count_o holds.
REQ-032 SHALL give abort_i priority over start_i; an abort in IDLE has no effect.
REQ-033 SHALL use no multipliers; totals follow from the counters only.

Reset
REQ-034 SHALL, while reset=1 at a clock edge, force state IDLE and all outputs to 0, overriding start_i and abort_i, including mid-burst.
REQ-035 SHALL accept start_i in the first cycle after reset deasserts.

Verification
REQ-036 SHALL cover: n=2, passes=1, ready_i=1, start at cycle 0 -> valid_o at cycles 2-17, last_o at 9 and 17, pass_last_o at 17, done_o at 18, beat_count_o=16.
REQ-037 SHALL cover: same job with ready_i=0 only at cycle 9 -> second burst at 11-18, done_o at 19.
REQ-038 SHALL cover: n=0, passes=5, start -> done_o at cycle 1, no valid_o, beat_count_o=0.
REQ-039 SHALL cover: n=3, passes=2, abort_i at the 4th beat of burst 1 -> valid_o low next cycle, aborted_o=1, no done_o, beat_count_o=12.
REQ-040 SHALL cover: reset mid-burst, then start with n=1, passes=1 -> 8 beats, done_o, beat_count_o=8.
REQ-041 SHALL cover: start_i repeated during RUN -> no effect; total beats = n*passes*BURST.
